// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_detect_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_NONE = 2'b00;
    localparam edge_mode_t EDGE_RISE = 2'b01;
    localparam edge_mode_t EDGE_FALL = 2'b10;
    localparam edge_mode_t EDGE_BOTH = 2'b11;

    // Ceiling log2, used to size the glitch-filter counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // True when a transition in the given direction should be reported.
    function automatic logic mode_match(input edge_mode_t m, input logic rising);
        if (m == EDGE_BOTH) return 1'b1;
        return rising ? (m == EDGE_RISE) : (m == EDGE_FALL);
    endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// One channel: synchroniser -> glitch filter -> edge compare -> sticky flag.
// Build option EDGE_FILTER_EN: when defined, a level change must persist for
// FILT_CYCLES cycles before it is accepted; otherwise every synchronised
// change is accepted on the next edge and FILT_CYCLES is ignored.
module edge_filter_chan
    import edge_detect_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_in,
    input  edge_mode_t edge_mode,
    input  logic       sticky_clr,
    output logic       level_out,
    output logic       edge_sig,
    output logic       edge_nxt,
    output logic       sticky
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   edge_q, edge_d;
    logic                   sticky_q, sticky_d;
    logic                   s;
    logic                   toggle;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
    localparam int           CW      = clog2(FILT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);
    logic [CW-1:0]           cnt_q, cnt_d;
`endif

    // Next-state: shift synchroniser, qualify level change, decode edge, sticky.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        toggle = 1'b0;
`ifdef EDGE_FILTER_EN
        cnt_d  = cnt_q;
        if (s == level_q) begin
            cnt_d = '0;                 // returning to level drops partial count
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            toggle = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
`else
        toggle = (s != level_q);
`endif
        level_d  = toggle ? s : level_q;
        // Mode is sampled only at the toggle edge, so mode changes never
        // produce a late edge.
        edge_d   = toggle & mode_match(edge_mode, s);
        // Set has priority over a simultaneous clear.
        sticky_d = edge_q | (sticky_q & ~sticky_clr);
    end

    // State registers with synchronous reset to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
            level_q  <= IDLE_LEVEL;
            edge_q   <= 1'b0;
            sticky_q <= 1'b0;
`ifdef EDGE_FILTER_EN
            cnt_q    <= '0;
`endif
        end else begin
            sync_q   <= sync_d;
            level_q  <= level_d;
            edge_q   <= edge_d;
            sticky_q <= sticky_d;
`ifdef EDGE_FILTER_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign level_out = level_q;
    assign edge_sig  = edge_q;
    assign edge_nxt  = edge_d;
    assign sticky    = sticky_q;

endmodule

// File: rtl/edge_detect_array.sv
// Multi-channel edge detector: CH independent channels plus a registered
// OR of all edge pulses. Build option EDGE_FILTER_EN enables the per-channel
// glitch filter (see edge_filter_chan).
module edge_detect_array
    import edge_detect_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   Pin_In,
    input  logic [2*CH-1:0] Edge_Mode,
    input  logic [CH-1:0]   Sticky_Clr,
    output logic [CH-1:0]   Level_Out,
    output logic [CH-1:0]   Edge_Sig,
    output logic            Any_Edge,
    output logic [CH-1:0]   Sticky
);

    logic [CH-1:0] edge_nxt;
    logic          any_edge_q, any_edge_d;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_filter_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .pin_in    (Pin_In[i]),
            .edge_mode (edge_mode_t'(Edge_Mode[2*i+1:2*i])),
            .sticky_clr(Sticky_Clr[i]),
            .level_out (Level_Out[i]),
            .edge_sig  (Edge_Sig[i]),
            .edge_nxt  (edge_nxt[i]),
            .sticky    (Sticky[i])
        );
    end

    // OR the next-cycle pulses so Any_Edge lines up with Edge_Sig.
    always_comb begin
        any_edge_d = |edge_nxt;
    end

    // Any_Edge register.
    always_ff @(posedge CLK) begin
        if (RST) any_edge_q <= 1'b0;
        else     any_edge_q <= any_edge_d;
    end

    assign Any_Edge = any_edge_q;

endmodule

// File: tb/tb_edge_detect_array.sv
// Directed self-checking bench for edge_detect_array (CH=4, SYNC=2, FILT=4).
// Expected timing follows EDGE_FILTER_EN: the toggle edge index T is
// SYNC+FILT-1 with the filter, SYNC without it.
module tb_edge_detect_array;

    localparam int CH = 4;
`ifdef EDGE_FILTER_EN
    localparam int T = 5;
`else
    localparam int T = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   pin;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   lvl, edg, stk;
    logic            any;

    int n_cmp = 0;
    int n_bad = 0;

    edge_detect_array #(.CH(CH), .SYNC_STAGES(2), .FILT_CYCLES(4), .IDLE_LEVEL(1'b1)) dut (
        .CLK(clk), .RST(rst), .Pin_In(pin), .Edge_Mode(mode), .Sticky_Clr(clr),
        .Level_Out(lvl), .Edge_Sig(edg), .Any_Edge(any), .Sticky(stk)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [CH-1:0]   pin;
        logic [2*CH-1:0] mode;
        logic [CH-1:0]   clr;
        int              n;
        logic [CH-1:0]   lvl, edg;
        logic            any;
        logic [CH-1:0]   stk;
    } vec_t;

    vec_t tbl[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int pulses;
        logic prev;

        // ch0 in fall mode: fall reported, return rise ignored, then clear
        tbl[0] = '{"idle",         4'hF, 8'h02, 4'h0, 1, 4'hF, 4'h0, 1'b0, 4'h0};
        tbl[1] = '{"fall_pre",     4'hE, 8'h02, 4'h0, T, 4'hF, 4'h0, 1'b0, 4'h0};
        tbl[2] = '{"fall_hit",     4'hE, 8'h02, 4'h0, 1, 4'hE, 4'h1, 1'b1, 4'h0};
        tbl[3] = '{"fall_post",    4'hE, 8'h02, 4'h0, 1, 4'hE, 4'h0, 1'b0, 4'h1};
        tbl[4] = '{"fall_hold",    4'hE, 8'h02, 4'h0, 8, 4'hE, 4'h0, 1'b0, 4'h1};
        tbl[5] = '{"rise_pre",     4'hF, 8'h02, 4'h0, T, 4'hE, 4'h0, 1'b0, 4'h1};
        tbl[6] = '{"rise_nopulse", 4'hF, 8'h02, 4'h0, 1, 4'hF, 4'h0, 1'b0, 4'h1};
        tbl[7] = '{"sticky_clr",   4'hF, 8'h02, 4'h1, 1, 4'hF, 4'h0, 1'b0, 4'h0};
        tbl[8] = '{"clr_idle",     4'hF, 8'h02, 4'h0, 3, 4'hF, 4'h0, 1'b0, 4'h0};

        // Reset state and quiet hold
        rst = 1'b1; pin = 4'hF; mode = '0; clr = '0;
        repeat (3) step();
        chk("reset_state", {lvl, edg, any, stk}, {4'hF, 4'h0, 1'b0, 4'h0});
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("reset_hold", {lvl, edg, any, stk}, {4'hF, 4'h0, 1'b0, 4'h0});
        end

        // Table vectors
        for (int v = 0; v < 9; v++) begin
            pin = tbl[v].pin; mode = tbl[v].mode; clr = tbl[v].clr;
            for (int c = 0; c < tbl[v].n; c++) begin
                step();
                if (c < tbl[v].n - 1) chk({tbl[v].name, "_quiet"}, 32'(edg), 32'h0);
            end
            chk({tbl[v].name, "_lvl"}, 32'(lvl), 32'(tbl[v].lvl));
            chk({tbl[v].name, "_edge"}, 32'(edg), 32'(tbl[v].edg));
            chk({tbl[v].name, "_any"}, 32'(any), 32'(tbl[v].any));
            chk({tbl[v].name, "_sticky"}, 32'(stk), 32'(tbl[v].stk));
        end
        clr = '0;

        // ch2 both-edge square wave: one pulse per transition
        mode = 8'h30; pulses = 0; prev = 1'b0;
        for (int h = 0; h < 5; h++) begin
            if (h < 4) pin[2] = ~pin[2];
            for (int c = 0; c < 8; c++) begin
                step();
                if (edg[2] && prev) chk("sq_double_pulse", 32'(edg[2] & prev), 32'h0);
                prev = edg[2];
                if (edg[2]) pulses++;
            end
        end
        chk("sq_both_pulses", pulses, 4);
        chk("sq_both_sticky", 32'(stk[2]), 32'h1);

        // Mode 00: no pulses but level still tracks
        mode = 8'h00; pulses = 0;
        for (int h = 0; h < 4; h++) begin
            pin[2] = ~pin[2];
            for (int c = 0; c < 8; c++) begin
                step();
                if (edg[2]) pulses++;
            end
            chk("none_level_tracks", 32'(lvl[2]), 32'(pin[2]));
        end
        chk("none_pulses", pulses, 0);
        chk("none_any", 32'(any), 32'h0);

        // Sticky set wins over clear in the same cycle, then clear alone
        step(); clr = 4'h4; step(); clr = '0;
        mode = 8'h02; pin[0] = 1'b0;
        repeat (T + 1) step();
        chk("setwin_edge", 32'(edg[0]), 32'h1);
        clr = 4'h1;
        step();
        chk("setwin_sticky", 32'(stk[0]), 32'h1);
        step();
        chk("clr_alone_sticky", 32'(stk[0]), 32'h0);
        clr = '0; pin[0] = 1'b1;
        repeat (T + 3) step();

        // ch1 fall: short-pulse behaviour
        mode = 8'h08; pulses = 0;
`ifdef EDGE_FILTER_EN
        pin[1] = 1'b0; repeat (3) step(); pin[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (edg[1]) pulses++;
        end
        chk("glitch3_pulses", pulses, 0);
        chk("glitch3_level", 32'(lvl[1]), 32'h1);
        pulses = 0;
        pin[1] = 1'b0; repeat (4) step(); pin[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (edg[1]) pulses++;
        end
        chk("pulse4_pulses", pulses, 1);
        chk("pulse4_level", 32'(lvl[1]), 32'h1);
`else
        pin[1] = 1'b0; step(); pin[1] = 1'b1;
        step();
        chk("nofilt_early", 32'(edg[1]), 32'h0);
        step();
        chk("nofilt_pulse", 32'(edg[1]), 32'h1);
        chk("nofilt_any", 32'(any), 32'h1);
        repeat (6) step();
        chk("nofilt_level", 32'(lvl[1]), 32'h1);
`endif

        // Reset mid-count discards partial progress
        mode = 8'h80; pin = 4'h7;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_state", {lvl, edg, any, stk}, {4'hF, 4'h0, 1'b0, 4'h0});
        rst = 1'b0; pulses = 0;
        for (int c = 0; c < T; c++) begin
            step();
            if (edg != 0) pulses++;
        end
        chk("midrst_quiet", pulses, 0);
        step();
        chk("midrst_edge", 32'(edg), 32'h8);
        chk("midrst_any", 32'(any), 32'h1);
        chk("midrst_level", 32'(lvl), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
